// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with run-time parity and a one-word valid/ready output register.
// Latency: word registered one clk after the mid-bit sample of the last stop bit; a word that completes while the held word is unaccepted is dropped and flagged as overrun.
module uart_rx_cfg #(
    parameter int Oversample = 16,
    parameter int DataBits   = 8,
    parameter int StopBits   = 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_en,
    input  logic                i_in,
    input  logic [1:0]          i_parity_mode,
    output logic [DataBits-1:0] o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_parity_err,
    output logic                o_frame_err,
    output logic                o_brk,
    output logic                o_overrun,
    output logic                o_busy
);

    localparam int CW = $clog2(Oversample);
    localparam int BW = $clog2(DataBits + 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(Oversample - 1);
    localparam logic [CW-1:0] CNT_MID = CW'(Oversample / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_sync1, r_sync_in, r_sync_prev;
    logic [CW-1:0]       r_cnt;
    logic [BW-1:0]       r_bit_cnt;
    logic [DataBits-1:0] r_shift;
    logic [1:0]          r_par_mode;
    logic                r_perr, r_ferr, r_par_bit, r_stop0_low;
    logic [DataBits-1:0] r_data;
    logic                r_valid, r_perr_o, r_ferr_o, r_brk_o, r_overrun;

    logic w_start_det, w_mid, w_wrap, w_par_en, w_last_stop, w_complete;
    logic w_ferr_final, w_first_stop_low, w_brk, w_hs, w_load, w_drop;

    assign w_start_det      = i_en && r_sync_prev && !r_sync_in;
    assign w_mid            = i_en && (r_cnt == CNT_MID);
    assign w_wrap           = i_en && (r_cnt == '0);
    assign w_par_en         = (r_par_mode == 2'b01) || (r_par_mode == 2'b10);
    assign w_last_stop      = (r_bit_cnt == BW'(StopBits - 1));
    assign w_complete       = (r_state == S_STOP) && w_mid && w_last_stop;
    assign w_ferr_final     = r_ferr || !r_sync_in;
    // With one stop bit the first stop sample is the one being taken right now.
    assign w_first_stop_low = (r_bit_cnt == '0) ? !r_sync_in : r_stop0_low;
    assign w_brk            = (r_shift == '0) && (!w_par_en || !r_par_bit) && w_first_stop_low;
    assign w_hs             = r_valid && i_ready;
    assign w_load           = w_complete && (!r_valid || i_ready);
    assign w_drop           = w_complete && r_valid && !i_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_start_det) w_state_nxt = S_START;
            S_START: begin
                if (w_mid && r_sync_in) w_state_nxt = S_IDLE;
                else if (w_wrap)        w_state_nxt = S_DATA;
            end
            S_DATA:      if (w_wrap && (r_bit_cnt == BW'(DataBits)))
                             w_state_nxt = w_par_en ? S_PARITY : S_STOP;
            S_PARITY:    if (w_wrap) w_state_nxt = S_STOP;
            S_STOP:      if (w_complete) w_state_nxt = w_ferr_final ? S_WAIT_IDLE : S_IDLE;
            S_WAIT_IDLE: if (i_en && r_sync_in) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy       = (r_state != S_IDLE);
        o_data       = r_data;
        o_valid      = r_valid;
        o_parity_err = r_perr_o;
        o_frame_err  = r_ferr_o;
        o_brk        = r_brk_o;
        o_overrun    = r_overrun;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1     <= 1'b1;
            r_sync_in   <= 1'b1;
            r_sync_prev <= 1'b1;
            r_cnt       <= CNT_TOP;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_mode  <= 2'b00;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_par_bit   <= 1'b0;
            r_stop0_low <= 1'b0;
        end else begin
            r_sync1   <= i_in;
            r_sync_in <= r_sync1;
            if (i_en) begin
                r_sync_prev <= r_sync_in;
                r_cnt <= (r_state == S_IDLE || r_cnt == '0) ? CNT_TOP : r_cnt - CW'(1);
                case (r_state)
                    S_IDLE: if (w_start_det) begin
                        r_par_mode <= i_parity_mode;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                    end
                    S_START: if (w_mid) r_bit_cnt <= '0;
                    S_DATA: begin
                        if (w_mid) begin
                            r_shift   <= {r_sync_in, r_shift[DataBits-1:1]};
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end else if (w_wrap && (r_bit_cnt == BW'(DataBits))) begin
                            r_bit_cnt <= '0;
                        end
                    end
                    S_PARITY: if (w_mid) begin
                        r_par_bit <= r_sync_in;
                        r_perr    <= r_sync_in != ((^r_shift) ^ (r_par_mode == 2'b10));
                    end
                    S_STOP: if (w_mid) begin
                        if (!r_sync_in)        r_ferr      <= 1'b1;
                        if (r_bit_cnt == '0)   r_stop0_low <= !r_sync_in;
                        r_bit_cnt <= r_bit_cnt + BW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output register runs every clk so the consumer handshake does not depend on en.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr_o  <= 1'b0;
            r_ferr_o  <= 1'b0;
            r_brk_o   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_data   <= r_shift;
                r_perr_o <= r_perr;
                r_ferr_o <= w_ferr_final;
                r_brk_o  <= w_brk;
                r_valid  <= 1'b1;
            end else if (w_hs) begin
                r_valid  <= 1'b0;
            end
            if (w_hs)        r_overrun <= 1'b0;
            else if (w_drop) r_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed vector table, multi-cycle corner sequences and random frames vs a reference model.
module tb_uart_rx_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, in_a, ready_a;
    logic [1:0] pm_a;
    logic [7:0] data_a;
    logic       valid_a, pe_a, fe_a, bk_a, ov_a, busy_a;

    logic       rst_b, en_b, in_b, ready_b;
    logic [1:0] pm_b;
    logic [4:0] data_b;
    logic       valid_b, pe_b, fe_b, bk_b, ov_b, busy_b;

    uart_rx_cfg dut_a (
        .i_clk(clk), .i_reset(rst_a), .i_en(en_a), .i_in(in_a), .i_parity_mode(pm_a),
        .o_data(data_a), .o_valid(valid_a), .i_ready(ready_a), .o_parity_err(pe_a),
        .o_frame_err(fe_a), .o_brk(bk_a), .o_overrun(ov_a), .o_busy(busy_a)
    );

    uart_rx_cfg #(.Oversample(16), .DataBits(5), .StopBits(2)) dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_en(en_b), .i_in(in_b), .i_parity_mode(pm_b),
        .o_data(data_b), .o_valid(valid_b), .i_ready(ready_b), .o_parity_err(pe_b),
        .o_frame_err(fe_b), .o_brk(bk_b), .o_overrun(ov_b), .o_busy(busy_b)
    );

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } word_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] mode;
        logic       pbit;
        logic       stop;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_bk;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    int    t_busy = 0;
    int    t_valid = 0;
    logic  pbusy = 1'b0;
    logic  pvalid = 1'b0;
    logic  rand_ready = 1'b0;
    word_t qa[$];
    word_t qb[$];
    word_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Accepted words are captured at the handshake, away from the active edge.
    always @(negedge clk) begin
        if (!rst_a && valid_a && ready_a) qa.push_back({1'b0, data_a, pe_a, fe_a, bk_a});
        if (!rst_b && valid_b && ready_b) qb.push_back({4'b0, data_b, pe_b, fe_b, bk_b});
        if (busy_a && !pbusy)   t_busy  = cyc;
        if (valid_a && !pvalid) t_valid = cyc;
        pbusy  = busy_a;
        pvalid = valid_a;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        en_b = ((cyc % 4) == 0);
        if (rand_ready) ready_a = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_bit(input int which, input logic v, input int reps);
        if (which == 0) in_a = v;
        else            in_b = v;
        repeat (reps) tick();
    endtask

    // Frame: start, data LSB first, optional parity, stop bits (stops[0] first), then idle-high gap.
    task automatic send(input int which, input logic [8:0] d, input logic [1:0] mode,
                        input logic pbit, input logic [1:0] stops, input int gap_bits);
        int nd   = (which == 0) ? 8 : 5;
        int ns   = (which == 0) ? 1 : 2;
        int per  = (which == 0) ? 16 : 64;
        logic pe = (which == 0) && (mode == 2'b01 || mode == 2'b10);
        if (which == 0) pm_a = mode;
        drive_bit(which, 1'b0, per);
        // Parity mode must already be latched; scramble it for the rest of the frame.
        if (which == 0) pm_a = 2'($urandom_range(0, 3));
        for (int i = 0; i < nd; i++) drive_bit(which, d[i], per);
        if (pe) drive_bit(which, pbit, per);
        for (int i = 0; i < ns; i++) drive_bit(which, stops[i], per);
        for (int i = 0; i < gap_bits; i++) drive_bit(which, 1'b1, per);
    endtask

    function automatic word_t pop_a();
        if (qa.size() == 0) return '0;
        return qa.pop_front();
    endfunction

    function automatic word_t pop_b();
        if (qb.size() == 0) return '0;
        return qb.pop_front();
    endfunction

    function automatic word_t model(input logic [7:0] d, input logic [1:0] mode,
                                    input logic pbit, input logic stop_ok);
        int   ones   = $countones(d);
        logic par_on = (mode == 2'b01) || (mode == 2'b10);
        logic want   = (mode == 2'b10) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        word_t w;
        w.d  = {1'b0, d};
        w.pe = par_on && (pbit != want);
        w.fe = !stop_ok;
        w.bk = (d == 8'h00) && (!par_on || !pbit) && !stop_ok;
        return w;
    endfunction

    initial begin
        vec_t  vt[12];
        word_t w;
        logic [7:0] rd;
        logic [1:0] rm;
        logic       rp, rs;

        vt[0]  = '{8'hA5, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{8'h3C, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{8'h3C, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{8'h3C, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[5]  = '{8'hFF, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{8'h00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{8'h00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[8]  = '{8'h00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vt[9]  = '{8'h00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[10] = '{8'h5A, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[11] = '{8'h01, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b0;
        in_a = 1'b1;  in_b = 1'b1;  ready_a = 1'b1; ready_b = 1'b1;
        pm_a = 2'b00; pm_b = 2'b00;
        repeat (3) tick();
        check("reset_a", {data_a, valid_a, pe_a, fe_a, bk_a, ov_a, busy_a}, 32'h0);
        check("reset_b", {data_b, valid_b, pe_b, fe_b, bk_b, ov_b, busy_b}, 32'h0);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (20) tick();

        // Latency of a plain 8N1 frame.
        qa.delete();
        send(0, 9'h0A5, 2'b00, 1'b0, 2'b11, 2);
        check("latency", t_valid - t_busy, 153);
        check("latency_count", qa.size(), 1);
        w = pop_a();
        check("latency_word", w, {9'h0A5, 3'b000});

        // Directed vector table.
        foreach (vt[i]) begin
            qa.delete();
            send(0, {1'b0, vt[i].d}, vt[i].mode, vt[i].pbit, {1'b1, vt[i].stop}, 3);
            check($sformatf("vec%0d_count", i), qa.size(), 1);
            w = pop_a();
            check($sformatf("vec%0d_word", i), w,
                  {1'b0, vt[i].d, vt[i].exp_pe, vt[i].exp_fe, vt[i].exp_bk});
        end

        // Held break: one word only, busy until the line returns high.
        qa.delete();
        send(0, 9'h000, 2'b00, 1'b0, 2'b00, 0);
        drive_bit(0, 1'b0, 16 * 40);
        check("break_busy_low", busy_a, 1'b1);
        check("break_count", qa.size(), 1);
        w = pop_a();
        check("break_word", w, {9'h000, 3'b011});
        drive_bit(0, 1'b1, 32);
        check("break_busy_idle", busy_a, 1'b0);
        check("break_no_more", qa.size(), 0);

        // Overrun with the consumer stalled, then a single-clk accept.
        qa.delete();
        ready_a = 1'b0;
        send(0, 9'h011, 2'b00, 1'b0, 2'b11, 0);
        send(0, 9'h022, 2'b00, 1'b0, 2'b11, 2);
        check("ovr_valid", valid_a, 1'b1);
        check("ovr_data", data_a, 8'h11);
        check("ovr_flag", ov_a, 1'b1);
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        check("ovr_valid_fall", valid_a, 1'b0);
        check("ovr_clear", ov_a, 1'b0);
        check("ovr_accept_count", qa.size(), 1);
        w = pop_a();
        check("ovr_accept_word", w.d, 9'h011);
        ready_a = 1'b1;

        // Three-tick low glitch on an idle line.
        repeat (40) tick();
        qa.delete();
        in_a = 1'b0;
        repeat (3) tick();
        in_a = 1'b1;
        repeat (2) tick();
        check("glitch_busy", busy_a, 1'b1);
        repeat (8) tick();
        check("glitch_idle", busy_a, 1'b0);
        repeat (200) tick();
        check("glitch_no_word", {valid_a, 8'(qa.size())}, 9'h0);

        // Random frames with random consumer stalls against the model.
        qa.delete();
        exp_q.delete();
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            rd = 8'($urandom);
            if ($urandom_range(0, 5) == 0) rd = 8'h00;
            rm = 2'($urandom_range(0, 3));
            rp = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 4) != 0);
            send(0, {1'b0, rd}, rm, rp, {1'b1, rs}, $urandom_range(1, 3));
            exp_q.push_back(model(rd, rm, rp, rs));
        end
        rand_ready = 1'b0;
        ready_a = 1'b1;
        repeat (20) tick();
        check("rand_count", qa.size(), exp_q.size());
        foreach (exp_q[i]) begin
            w = pop_a();
            check($sformatf("rand%0d", i), w, exp_q[i]);
        end
        check("rand_no_overrun", ov_a, 1'b0);

        // 5 data bits, 2 stop bits, en every 4th clk.
        qb.delete();
        send(1, 9'h015, 2'b00, 1'b0, 2'b11, 2);
        check("b_count1", qb.size(), 1);
        w = pop_b();
        check("b_word1", w, {9'h015, 3'b000});
        send(1, 9'h015, 2'b00, 1'b0, 2'b01, 2);
        check("b_count2", qb.size(), 1);
        w = pop_b();
        check("b_word2", w, {9'h015, 3'b010});
        ready_b = 1'b0;
        send(1, 9'h00A, 2'b00, 1'b0, 2'b11, 1);
        check("b_held", {valid_b, data_b}, {1'b1, 5'h0A});

        // Reset in the middle of the data bits.
        drive_bit(1, 1'b0, 64);
        drive_bit(1, 1'b1, 64);
        drive_bit(1, 1'b0, 64);
        drive_bit(1, 1'b1, 64);
        check("b_busy_mid", busy_b, 1'b1);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        check("b_reset_mid", {data_b, valid_b, pe_b, fe_b, bk_b, ov_b, busy_b}, 32'h0);
        in_b = 1'b1;
        ready_b = 1'b1;
        repeat (400) tick();
        check("b_after_reset", {valid_b, busy_b, 8'(qb.size())}, 10'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receive block. Data width, stop-bit count and oversample ratio are set at elaboration. Parity mode is selected at run time. A one-word output register with a valid/ready handshake sits between the receiver and the consumer, so a downstream FIFO or bus bridge can apply backpressure. Parity, framing, break and overrun are reported per word.

Parameters:
Oversample, 16, enable ticks per bit period; >=4, even.
DataBits, 8, data bits per frame; legal 5..9.
StopBits, 1, stop bits expected; legal 1 or 2.

Ports:
clk  in  1  single clock.
reset  in  1  synchronous, active-high reset.
en  in  1  oversample tick; all receive logic advances only on cycles with en=1.
in  in  1  raw serial line, asynchronous; idles high.
parityMode  in  2  00 none, 01 even, 10 odd, 11 treated as none; sampled when a start bit is accepted.
data  out  DataBits  received word, LSB = first bit on the line.
valid  out  1  data and the error flags are held stable while 1.
ready  in  1  consumer accepts the word when valid&&ready.
parityErr  out  1  qualified by valid; parity mismatch.
frameErr  out  1  qualified by valid; a stop bit sampled low.
brk  out  1  qualified by valid; all data bits 0, parity bit 0 if enabled, first stop bit 0.
overrun  out  1  sticky; at least one frame dropped because valid was held.
busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE; synchroniser flops=1; sample counter=Oversample-1; bit counter=0.
  - data=0; valid=0; parityErr=0; frameErr=0; brk=0; overrun=0; busy=0.
  - Reset mid-frame aborts the frame and produces no output.
- Synchroniser: 2-flop synchroniser on in, clocked every clk and independent of en. syncIn is the second flop; syncPrev is syncIn delayed one en tick.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE -> START on en && syncPrev=1 && syncIn=0.
  - Load sample counter = Oversample-1.
  - Latch parityMode.
- Sample counter:
  - Decrements each en tick.
  - Wraps Oversample-1 -> 0 -> Oversample-1.
  - The mid-bit sample point is counter == Oversample/2 - 1, i.e. Oversample/2 ticks after the bit starts.
- START, at mid-bit:
  - syncIn=1 is a false start: go to IDLE, no output, no flags.
  - Otherwise clear the bit counter and go to DATA on the next bit boundary (counter wrap).
- DATA: at each mid-bit, shift syncIn in LSB-first. After DataBits samples go to PARITY if the latched mode is even or odd, else to STOP.
- PARITY: one bit.
  - Expected value = XOR of the data bits for even; its inverse for odd.
  - Mismatch sets an internal pErr.
- STOP: StopBits bits, each sampled at mid-bit.
  - Any low sample sets an internal fErr.
  - The word completes at the mid-bit sample of the last stop bit. It does not wait for the full bit, so back-to-back frames are not missed.
- Completion, same cycle as the final stop sample:
  - If valid=0, or valid&&ready this cycle: load data, parityErr, frameErr and brk; valid=1 next cycle.
  - Otherwise drop the word, keep the held word unchanged, and set overrun=1.
- After completion:
  - fErr=0 -> IDLE.
  - fErr=1 -> WAIT_IDLE. WAIT_IDLE holds until syncIn=1 is sampled on an en tick, then goes to IDLE. A held break therefore yields exactly one brk word.
- Handshake:
  - valid falls the cycle after valid&&ready unless a new word loads the same cycle. In that case valid stays 1 with the new contents.
  - valid, data and flags are independent of en.
- overrun clears only on a valid&&ready handshake, or on reset.
- en=0: state, counters and shift register hold; the synchroniser still runs.
- Latency: the word appears Oversample/2 + Oversample*(DataBits + P + StopBits - 1) + Oversample*1 en ticks after the start edge is detected (P = 1 if parity enabled, else 0), plus one clk for the output register.

Test Plan:
- Defaults, parityMode=00, send 0xA5 8N1, one en per clk, ready=1 -> valid pulses once 153 clks after the start edge is detected; data=0xA5; all flags 0.
- parityMode=01, send 0x3C with parity bit 1 (wrong) -> data=0x3C, parityErr=1, frameErr=0. Repeat with parity bit 0 -> parityErr=0. Repeat with parityMode=10 and parity bit 1 -> parityErr=0.
- Stop bit driven low on 0x00, then line held low 40 bit times -> exactly one word: data=0x00, frameErr=1, brk=1; busy stays 1 until the line returns high; no further words.
- ready=0, send 0x11 then 0x22 back-to-back -> data stays 0x11, overrun=1. Raise ready for one clk -> valid falls, overrun=0.
- Low glitch of 3 en ticks on an idle line -> false start; no valid; busy back to 0 within 8 ticks.
- DataBits=5, StopBits=2, en every 4th clk, send 0x15 -> data=5'h15; second stop bit low gives frameErr=1. Assert reset mid-DATA -> all outputs 0, state IDLE next clk.
